// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment display path: hex segment table,
// blanking words and the buffer-update operations used by the scan driver.
package seg_scan_decoder_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-low {a,b,c,d,e,f,g}; index is the hex value.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [7:0]            SEG_BLANK = 8'hFF;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_STAGE,
        BUF_COMMIT,
        BUF_DIRECT
    } buf_op_e;

    function automatic logic [7:0] seg_word(input logic [6:0] seg_n, input logic dp_lit);
        return {seg_n, ~dp_lit};
    endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex-to-7-segment decoder, active-low {a..g}; shared by
// every display block that needs a hex glyph.
module seg_hex_lut
    import seg_scan_decoder_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_HEX[i_hex];

endmodule

// File: rtl/seg_scan_decoder.sv
// Time-multiplexed 7-segment driver: prescaled scan index, double-buffered
// digit latch so a frame never tears, and a registered anode/segment stage.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_MAX    = 49999
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [2:0]                digit_idx,
    output logic                      frame_done
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX  = DIV_WIDTH'(DIV_MAX);
    localparam logic [2:0]           IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [2:0]              r_idx;

    logic [4*NUM_DIGITS-1:0] r_stage_dig;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_dig;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [2:0]              r_digit_idx;

    logic                    w_tick;
    logic                    w_wrap;
    buf_op_e                 w_buf_op;
    logic [NUM_DIGITS-1:0]   w_sel_onehot;
    logic                    w_idx_valid;
    logic                    w_blank;
    logic                    w_dp;
    logic                    w_dark;
    logic [3:0]              w_cur_hex;
    logic [6:0]              w_seg_n;

    // The wrap cycle is the last enabled count of the last position; the
    // frame boundary commit and frame_done both key off it.
    assign w_tick = en && (r_cnt == CNT_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_buf_op = BUF_HOLD;
        if (w_wrap && load) begin
            w_buf_op = BUF_DIRECT;
        end else if (w_wrap && r_pending) begin
            w_buf_op = BUF_COMMIT;
        end else if (load) begin
            w_buf_op = BUF_STAGE;
        end
    end

    // NOTE: the digit buffers are plain flops, not RAM, so they take the
    // async reset; a reset mid-scan also drops any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_dig <= '0;
            r_stage_dp  <= '0;
            r_disp_dig  <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            case (w_buf_op)
                BUF_STAGE: begin
                    r_stage_dig <= digits_in;
                    r_stage_dp  <= dp_in;
                    r_pending   <= 1'b1;
                end
                BUF_COMMIT: begin
                    r_disp_dig <= r_stage_dig;
                    r_disp_dp  <= r_stage_dp;
                    r_pending  <= 1'b0;
                end
                BUF_DIRECT: begin
                    r_disp_dig <= digits_in;
                    r_disp_dp  <= dp_in;
                    r_pending  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // An index outside the populated positions selects nothing and stays dark.
    assign w_sel_onehot = NUM_DIGITS'(1) << r_idx;
    assign w_idx_valid  = |w_sel_onehot;
    assign w_blank      = |(blank_mask & w_sel_onehot);
    assign w_dp         = |(r_disp_dp & w_sel_onehot);
    assign w_dark       = !en || !w_idx_valid || w_blank;

    always_comb begin
        w_cur_hex = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_cur_hex = r_disp_dig[4*k +: 4];
            end
        end
    end

    seg_hex_lut u_hex_lut (
        .i_hex   (w_cur_hex),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg       <= SEG_BLANK;
            r_an        <= ANODE_OFF[NUM_DIGITS-1:0];
            r_digit_idx <= '0;
        end else begin
            r_seg       <= w_dark ? SEG_BLANK : seg_word(w_seg_n, w_dp);
            r_an        <= w_dark ? ANODE_OFF[NUM_DIGITS-1:0] : ~w_sel_onehot;
            r_digit_idx <= r_idx;
        end
    end

    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign digit_idx  = r_digit_idx;
    assign frame_done = w_wrap;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder with a fast prescaler (DIV_MAX=3),
// driven by directed scenarios plus random traffic against a time-based model.
module tb_seg_scan_decoder;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int DM = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [31:0]  digits_in = '0;
    logic [7:0]   dp_in = '0;
    logic [7:0]   blank_mask = '0;
    logic [7:0]   seg_out;
    logic [7:0]   an_out;
    logic [2:0]   digit_idx;
    logic         frame_done;

    int tests_run = 0;
    int tests_failed = 0;

    seg_scan_decoder #(.NUM_DIGITS(N), .DIV_WIDTH(DW), .DIV_MAX(DM)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] SEG7 [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: m_t counts enabled cycles since reset; position and count derive from it.
    int         m_t;
    logic [3:0] m_disp [N];
    logic [7:0] m_disp_dp;
    logic [3:0] m_stage [N];
    logic [7:0] m_stage_dp;
    bit         m_pending;
    logic [7:0] e_an, e_seg;
    logic [2:0] e_idx;
    logic       e_fd;

    function automatic int m_pos();
        return (m_t / (DM + 1)) % N;
    endfunction

    function automatic int m_cnt();
        return m_t % (DM + 1);
    endfunction

    task automatic model_reset();
        m_t = 0;
        for (int k = 0; k < N; k++) begin
            m_disp[k]  = '0;
            m_stage[k] = '0;
        end
        m_disp_dp  = '0;
        m_stage_dp = '0;
        m_pending  = 0;
        e_an = 8'hFF; e_seg = 8'hFF; e_idx = '0; e_fd = 1'b0;
    endtask

    // One clock: predict post-edge outputs from current inputs, apply the
    // buffering rules, then land on the following negedge.
    task automatic advance();
        int pos;
        bit wrap;
        pos  = m_pos();
        wrap = en && (m_cnt() == DM) && (pos == N - 1);
        if (!en || blank_mask[pos]) begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
        end else begin
            e_an  = ~(8'(1) << pos);
            e_seg = {SEG7[m_disp[pos]], ~m_disp_dp[pos]};
        end
        e_idx = 3'(pos);
        if (wrap) begin
            if (load) begin
                for (int k = 0; k < N; k++) m_disp[k] = digits_in[4*k +: 4];
                m_disp_dp = dp_in;
            end else if (m_pending) begin
                for (int k = 0; k < N; k++) m_disp[k] = m_stage[k];
                m_disp_dp = m_stage_dp;
            end
            m_pending = 0;
        end else if (load) begin
            for (int k = 0; k < N; k++) m_stage[k] = digits_in[4*k +: 4];
            m_stage_dp = dp_in;
            m_pending  = 1;
        end
        if (en) m_t++;
        @(posedge clk);
        @(negedge clk);
        e_fd = en && (m_cnt() == DM) && (m_pos() == N - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        digits_in = '0; dp_in = '0; blank_mask = '0;
        repeat (2) @(negedge clk);
        model_reset();
        if (an_out !== 8'hFF || seg_out !== 8'hFF || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values an=%h seg=%h idx=%0d fd=%b required FF FF 0 0",
                     an_out, seg_out, digit_idx, frame_done);
        end
        tests_run++;
        rst = 1'b0; en = 1'b1;
        if (an_out !== 8'hFF || seg_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL release_first_cycle an=%h seg=%h required FF FF", an_out, seg_out);
        end
        tests_run++;
        advance();
        if (an_out !== 8'hFE) begin
            tests_failed++;
            $display("FAIL release_latency an=%h required FE", an_out);
        end
        tests_run++;
    endtask

    task automatic test_load_basic();
        logic [7:0] rec [3];
        bit         got [3];
        bit         seen = 0;
        got = '{0, 0, 0};
        load = 1'b1; digits_in = 32'h76543210; dp_in = '0;
        advance();
        load = 1'b0;
        for (int i = 0; i < 48; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL load_basic_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (seen && digit_idx < 3 && !got[digit_idx]) begin
                rec[digit_idx] = seg_out;
                got[digit_idx] = 1;
            end
            if (frame_done === 1'b1) seen = 1;
        end
        if (!(got[0] && got[1] && got[2]) || rec[0] !== 8'b00000011 || rec[1] !== 8'b10011111
            || rec[2] !== 8'b00100101) begin
            tests_failed++;
            $display("FAIL load_basic_glyphs seen=%0d p0=%b p1=%b p2=%b required 00000011 10011111 00100101",
                     seen, rec[0], rec[1], rec[2]);
        end
        tests_run++;
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int i = 0; i < 40; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL scan_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (i < 32 && frame_done === 1'b1) pulses++;
        end
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL frame_done_rate pulses=%0d in 32 cycles required 1", pulses);
        end
        tests_run++;
    endtask

    task automatic test_midframe_load();
        bit seen = 0, arm = 0;
        int budget = 0;
        while (m_pos() != 3 && budget < 64) begin
            advance();
            budget++;
        end
        if (budget >= 64) begin
            tests_failed++;
            $display("FAIL midframe_wait budget expired pos=%0d required 3", m_pos());
        end
        tests_run++;
        load = 1'b1; digits_in = 32'hFFFFFFFF; dp_in = '0;
        advance();
        load = 1'b0;
        for (int i = 0; i < 64; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL midframe_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (!seen && digit_idx == 3'd4) begin
                if (seg_out !== 8'b10011001) begin
                    tests_failed++;
                    $display("FAIL midframe_old_digit seg=%b required 10011001", seg_out);
                end
                tests_run++;
            end
            if (seen && digit_idx == 3'd0) arm = 1;
            if (arm && seg_out !== 8'b01110001) begin
                tests_failed++;
                $display("FAIL midframe_new_digit idx=%0d seg=%b required 01110001", digit_idx, seg_out);
            end
            if (frame_done === 1'b1) seen = 1;
        end
    endtask

    task automatic test_wrap_load();
        int budget = 0;
        int frames = 0;
        int checked = 0;
        bit after = 0;
        if (frame_done === 1'b1) advance();
        load = 1'b1; digits_in = 32'h11111111; dp_in = '0;
        advance();
        load = 1'b0;
        while (frame_done !== 1'b1 && budget < 64) begin
            advance();
            budget++;
        end
        if (budget >= 64) begin
            tests_failed++;
            $display("FAIL wrap_wait budget expired fd=%b required 1", frame_done);
        end
        tests_run++;
        load = 1'b1; digits_in = 32'hAAAAAAAA; dp_in = '0;
        advance();
        load = 1'b0;
        for (int i = 0; i < 70; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL wrap_load_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (digit_idx == 3'd0 && !after) begin
                after = 1;
                checked++;
                if (seg_out !== 8'b00010001) begin
                    tests_failed++;
                    $display("FAIL wrap_load_glyph frame=%0d seg=%b required 00010001", frames, seg_out);
                end
                tests_run++;
            end
            if (digit_idx != 3'd0) after = 0;
            if (frame_done === 1'b1) frames++;
        end
        if (checked < 2) begin
            tests_failed++;
            $display("FAIL wrap_load_frames checked=%0d required >=2", checked);
        end
        tests_run++;
    endtask

    task automatic test_blank_dp();
        logic [7:0] last0 = 8'hFF;
        load = 1'b1; digits_in = 32'h33333333; dp_in = 8'h01; blank_mask = 8'h04;
        advance();
        load = 1'b0;
        for (int i = 0; i < 80; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL blank_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (digit_idx == 3'd2 && (an_out !== 8'hFF || seg_out !== 8'hFF)) begin
                tests_failed++;
                $display("FAIL blank_pos2 an=%h seg=%h required FF FF", an_out, seg_out);
            end
            if (digit_idx == 3'd0) last0 = seg_out;
        end
        if (last0[0] !== 1'b0 || last0[7:1] !== 7'b0000110) begin
            tests_failed++;
            $display("FAIL dp_pos0 seg=%b required 00001100", last0);
        end
        tests_run++;
        blank_mask = '0;
    endtask

    task automatic test_enable();
        int budget = 0;
        while (!(m_pos() == 5 && m_cnt() == 1) && budget < 64) begin
            advance();
            budget++;
        end
        if (budget >= 64) begin
            tests_failed++;
            $display("FAIL enable_wait budget expired pos=%0d cnt=%0d required 5 1", m_pos(), m_cnt());
        end
        tests_run++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL enable_off_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
            if (digit_idx !== 3'd5 || an_out !== 8'hFF || seg_out !== 8'hFF) begin
                tests_failed++;
                $display("FAIL enable_off_dark idx=%0d an=%h seg=%h required 5 FF FF",
                         digit_idx, an_out, seg_out);
            end
        end
        en = 1'b1;
        advance();
        if (digit_idx !== 3'd5 || an_out !== 8'hDF) begin
            tests_failed++;
            $display("FAIL enable_resume idx=%0d an=%h required 5 DF", digit_idx, an_out);
        end
        tests_run++;
        for (int i = 0; i < 6; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL enable_resume_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            load       = ($urandom_range(0, 9) == 0);
            digits_in  = $urandom;
            dp_in      = 8'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL random_model i=%0d an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         i, an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
        end
        en = 1'b1; load = 1'b0; blank_mask = '0; dp_in = '0;
    endtask

    task automatic test_reset_mid();
        if (frame_done === 1'b1) advance();
        load = 1'b1; digits_in = 32'h12345678; dp_in = 8'hFF;
        advance();
        load = 1'b0;
        repeat (3) advance();
        #2 rst = 1'b1;
        #1;
        if (an_out !== 8'hFF || seg_out !== 8'hFF || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async an=%h seg=%h fd=%b required FF FF 0", an_out, seg_out, frame_done);
        end
        tests_run++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            advance();
            if (an_out !== e_an || seg_out !== e_seg || digit_idx !== e_idx || frame_done !== e_fd) begin
                tests_failed++;
                $display("FAIL reset_mid_model an=%h/%h seg=%b/%b idx=%0d/%0d fd=%b/%b",
                         an_out, e_an, seg_out, e_seg, digit_idx, e_idx, frame_done, e_fd);
            end
            tests_run++;
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_scan();
        test_midframe_load();
        test_wrap_load();
        test_blank_dp();
        test_enable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
